// File: rtl/ysyx_22050019_divider.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle, a sign-fix cycle, then the result is held until consumed.
module ysyx_22050019_divider #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic            div_flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned WLEN = 32;
  localparam int unsigned CW   = $clog2(XLEN) + 1;
  localparam int unsigned UW   = XLEN - WLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [WLEN-1:0] MIN_W = {1'b1, {(WLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W_SEXT = {{(UW+1){1'b1}}, {(WLEN-1){1'b0}}};

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_dq;      // dividend bits shifting out, quotient bits shifting in
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rem;
  logic            r_word;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_remd;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_val;
  logic [XLEN-1:0] w_b_val;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN-1:0] w_a_sext;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;
  logic            w_qbit;
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_q_raw;
  logic [XLEN-1:0] w_q_sgn;
  logic [XLEN-1:0] w_r_sgn;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  assign div_ready = r_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_remd;

  // Operand decode at accept: word operands extended, magnitudes taken for signed ops
  assign w_a_neg  = div_signed & (div_word ? dividend[WLEN-1] : dividend[XLEN-1]);
  assign w_b_neg  = div_signed & (div_word ? divisor[WLEN-1]  : divisor[XLEN-1]);
  assign w_a_val  = div_word ? {{UW{div_signed & dividend[WLEN-1]}}, dividend[WLEN-1:0]} : dividend;
  assign w_b_val  = div_word ? {{UW{div_signed & divisor[WLEN-1]}}, divisor[WLEN-1:0]} : divisor;
  assign w_a_abs  = w_a_neg ? (XLEN'(0) - w_a_val) : w_a_val;
  assign w_b_abs  = w_b_neg ? (XLEN'(0) - w_b_val) : w_b_val;
  assign w_a_sext = {{UW{dividend[WLEN-1]}}, dividend[WLEN-1:0]};
  assign w_div0   = div_word ? (divisor[WLEN-1:0] == '0) : (divisor == '0);
  assign w_ovf    = div_signed & (div_word
                    ? ((dividend[WLEN-1:0] == MIN_W) && (divisor[WLEN-1:0] == '1))
                    : ((dividend == MIN_D) && (divisor == '1)));

  // One restoring step: shift in next dividend bit, subtract divisor if it fits
  assign w_shift    = {r_rem, r_dq[XLEN-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_trial[XLEN];
  assign w_step_rem = w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];

  // Sign fix and word sign-extension of the final result
  assign w_q_raw = r_word ? {{UW{1'b0}}, r_dq[WLEN-1:0]} : r_dq;
  assign w_q_sgn = r_q_neg ? (XLEN'(0) - w_q_raw) : w_q_raw;
  assign w_r_sgn = r_r_neg ? (XLEN'(0) - r_rem) : r_rem;
  assign w_q_fix = r_word ? {{UW{w_q_sgn[WLEN-1]}}, w_q_sgn[WLEN-1:0]} : w_q_sgn;
  assign w_r_fix = r_word ? {{UW{w_r_sgn[WLEN-1]}}, w_r_sgn[WLEN-1:0]} : w_r_sgn;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    w_next = r_state;
    if (div_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (div_valid) w_next = (w_div0 || w_ovf) ? S_DONE : S_CALC;
        S_CALC:  if (r_cnt == CW'(1)) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  if (out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Registered handshake outputs follow the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_ready     <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  // Datapath: operand capture, iteration, result registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_dq    <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_word  <= 1'b0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
    end else if (!div_flush) begin
      case (r_state)
        S_IDLE: begin
          if (div_valid) begin
            if (w_div0) begin
              r_quot <= '1;
              r_remd <= div_word ? w_a_sext : dividend;
            end else if (w_ovf) begin
              r_quot <= div_word ? MIN_W_SEXT : MIN_D;
              r_remd <= '0;
            end else begin
              r_dq    <= div_word ? {w_a_abs[WLEN-1:0], {UW{1'b0}}} : w_a_abs;
              r_dvs   <= w_b_abs;
              r_rem   <= '0;
              r_cnt   <= div_word ? CW'(WLEN) : CW'(XLEN);
              r_word  <= div_word;
              r_q_neg <= w_a_neg ^ w_b_neg;
              r_r_neg <= w_a_neg;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_step_rem;
          r_dq  <= {r_dq[XLEN-2:0], w_qbit};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_quot <= w_q_fix;
          r_remd <= w_r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_divider.sv
// Scoreboard bench for the iterative divider: a driver issues directed requests and
// pushes hand-computed results; a monitor pops and compares on each output handshake.
module tb_ysyx_22050019_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid;
  logic        div_ready;
  logic        div_signed;
  logic        div_word;
  logic        div_flush;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [63:0] remainder;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  ysyx_22050019_divider #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .div_word   (div_word),
    .div_flush  (div_flush),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare every accepted output against the oldest expected entry
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_quotient", quotient, e.q);
        check("sb_remainder", remainder, e.r);
      end
    end
  end

  // Issue one request, check latency and div_ready, optionally stall the consumer
  task automatic issue(input string name, input logic sgn, input logic wrd,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] eq, input logic [63:0] er,
                       input int exp_lat, input int hold);
    int          n;
    int          lat;
    logic        rdy_bad;
    logic        hold_bad;
    logic [63:0] hq;
    logic [63:0] hr;
    exp_t        e;
    n = 0;
    while (!div_ready && n < 200) begin @(posedge clk); #1; n++; end
    check({name, "_ready_in"}, 64'(div_ready), 64'd1);
    if (hold > 0) out_ready = 1'b0;
    e.q = eq;
    e.r = er;
    sb_q.push_back(e);
    div_valid = 1'b1; div_signed = sgn; div_word = wrd; dividend = a; divisor = b;
    @(posedge clk); #1;
    div_valid  = 1'b0;
    div_signed = ~sgn;
    div_word   = ~wrd;
    dividend   = {$urandom, $urandom};
    divisor    = {$urandom, $urandom};
    lat = 0; rdy_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (div_ready) rdy_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (div_ready) rdy_bad = 1'b1;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_ready_low"}, 64'(rdy_bad), 64'd0);
    if (hold > 0) begin
      hq = quotient; hr = remainder; hold_bad = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!out_valid || quotient !== hq || remainder !== hr) hold_bad = 1'b1;
      end
      check({name, "_held"}, 64'(hold_bad), 64'd0);
      out_ready = 1'b1;
    end
    n = 0;
    while (out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check({name, "_ready_after"}, 64'(div_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen;
    rst = 1'b1; div_valid = 1'b0; div_signed = 1'b0; div_word = 1'b0; div_flush = 1'b0;
    dividend = '0; divisor = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_quotient", quotient, 64'd0);
    check("reset_remainder", remainder, 64'd0);
    check("reset_div_ready", 64'(div_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    issue("divu_100_7",  1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 0);
    issue("div_m7_2",    1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    issue("div_7_m2",    1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
          64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 0);
    issue("divu_big",    1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
          64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65, 0);
    issue("divu_by0",    1'b0, 1'b0, 64'h1234, 64'd0,
          64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 0, 0);
    issue("divw_ovf",    1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 64'd0, 0, 0);
    issue("div_ovf",     1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 64'd0, 0, 0);
    issue("divw_by0",    1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_ABCD_0000_0000,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 0);
    issue("divuw_ff_1",  1'b0, 1'b1, 64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_0000_0000_0001,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33, 0);
    issue("divuw_100_7", 1'b0, 1'b1, 64'h5555_0000_0000_0064, 64'hAAAA_0000_0000_0007,
          64'd14, 64'd2, 33, 0);
    issue("divw_m7_2",   1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h7777_0000_0000_0002,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);

    // Consumer stall, then a back-to-back request right after the handshake
    issue("divu_hold",   1'b0, 1'b0, 64'd1000, 64'd3, 64'd333, 64'd1, 65, 10);
    issue("div_b2b",     1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
          64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);

    // Flush at CALC step 10 together with a new request: nothing captured, no result
    div_valid = 1'b1; div_signed = 1'b0; div_word = 1'b0; dividend = 64'd1000; divisor = 64'd3;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    div_flush = 1'b1; div_valid = 1'b1; dividend = 64'd5; divisor = 64'd0;
    @(posedge clk); #1;
    div_flush = 1'b0; div_valid = 1'b0;
    check("flush_ready", 64'(div_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", 64'(seen), 64'd0);

    // Asynchronous reset mid-CALC clears outputs without a clock edge
    div_valid = 1'b1; dividend = 64'd99; divisor = 64'd4;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_quotient", quotient, 64'd0);
    check("rst_remainder", remainder, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(div_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    n = 0;
    while (n < 80) begin
      @(posedge clk); #1; n++;
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_result", 64'(seen), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
